// File: rtl/delayed_data_memory.sv
// delayed_data_memory: single-port word memory behind the load/store unit's
// begin/end handshake. A request is accepted in IDLE, acknowledged with a
// one-cycle begin pulse, and serviced LATENCY edges later with a one-cycle end
// pulse. Writes are byte-masked; reads return the full word, registered.
// Optional build macro DMEM_BOUND_CHECK_EN: flag requests at or beyond
// 4*DEPTH_WORDS bytes (no write, read returns 0, memory_error pulses with end).
// Without the macro, addresses wrap modulo DEPTH_WORDS.
module delayed_data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_require,
  input  logic        memory_write_enable,
  input  logic [3:0]  memory_byte_enable_map,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  output logic [31:0] memory_read_data,
  output logic        memory_begin_signal,
  output logic        memory_end_signal,
  output logic        memory_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        counter_reg, counter_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic              write_enable_reg, write_enable_next;
  logic [3:0]        byte_enable_reg, byte_enable_next;
  logic [31:0]       write_data_reg, write_data_next;
  logic              out_of_range_reg, out_of_range_next;
  logic              begin_reg, begin_next;
  logic              end_reg, end_next;
  logic              error_reg, error_next;
  logic [31:0]       read_data_reg, read_data_next;

  logic              access_go;
  logic              request_out_of_range;
  logic [31:0]       array_word;
  logic [3:0]        lane_write;
  logic              unused_address_bits;

  // Only the word-index bits address the array; the rest are either
  // range-checked or deliberately dropped (wrap).
  assign unused_address_bits = ^{memory_address[31:IDX_W+2], memory_address[1:0]};

`ifdef DMEM_BOUND_CHECK_EN
  // Any set bit above the word-index field means address >= 4*DEPTH_WORDS.
  assign request_out_of_range = (memory_address >> (IDX_W + 2)) != 32'd0;
`else
  // Upper address bits are discarded, so every request is in range.
  assign request_out_of_range = 1'b0;
`endif

  // Byte lanes are stored as four independent 8-bit arrays so each lane maps
  // cleanly onto its own RAM column with a plain write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      assign lane_write[gi] = access_go & write_enable_reg & byte_enable_reg[gi] & ~out_of_range_reg;

      // Lane write at the access edge; contents survive reset.
      always_ff @(posedge clk) begin
        if (lane_write[gi]) begin
          lane_mem[index_reg] <= write_data_reg[8*gi +: 8];
        end
      end

      assign array_word[8*gi +: 8] = lane_mem[index_reg];
    end
  endgenerate

  // Handshake FSM next-state: latch on acceptance, count down, access, ack.
  always_comb begin
    state_next        = state_reg;
    counter_next      = counter_reg;
    index_next        = index_reg;
    write_enable_next = write_enable_reg;
    byte_enable_next  = byte_enable_reg;
    write_data_next   = write_data_reg;
    out_of_range_next = out_of_range_reg;
    begin_next        = 1'b0;
    end_next          = 1'b0;
    error_next        = 1'b0;
    read_data_next    = read_data_reg;
    access_go         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memory_require) begin
          index_next        = memory_address[IDX_W+1:2];
          write_enable_next = memory_write_enable;
          byte_enable_next  = memory_byte_enable_map;
          write_data_next   = memory_write_data;
          out_of_range_next = request_out_of_range;
          counter_next      = 4'(LATENCY - 1);
          begin_next        = 1'b1;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        if (counter_reg != 4'd0) begin
          counter_next = counter_reg - 4'd1;
        end else begin
          access_go  = 1'b1;
          end_next   = 1'b1;
          error_next = out_of_range_reg;
          state_next = DONE;
          if (!write_enable_reg) begin
            read_data_next = out_of_range_reg ? 32'd0 : array_word;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched request and output registers; reset drops any pending access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      counter_reg      <= 4'd0;
      index_reg        <= '0;
      write_enable_reg <= 1'b0;
      byte_enable_reg  <= 4'd0;
      write_data_reg   <= 32'd0;
      out_of_range_reg <= 1'b0;
      begin_reg        <= 1'b0;
      end_reg          <= 1'b0;
      error_reg        <= 1'b0;
      read_data_reg    <= 32'd0;
    end else begin
      state_reg        <= state_next;
      counter_reg      <= counter_next;
      index_reg        <= index_next;
      write_enable_reg <= write_enable_next;
      byte_enable_reg  <= byte_enable_next;
      write_data_reg   <= write_data_next;
      out_of_range_reg <= out_of_range_next;
      begin_reg        <= begin_next;
      end_reg          <= end_next;
      error_reg        <= error_next;
      read_data_reg    <= read_data_next;
    end
  end

  assign memory_read_data    = read_data_reg;
  assign memory_begin_signal = begin_reg;
  assign memory_end_signal   = end_reg;
  assign memory_error        = error_reg;

endmodule

// File: tb/tb_delayed_data_memory.sv
// tb_delayed_data_memory: randomized and directed transactions against a
// word-array reference model of the delayed data memory.
module tb_delayed_data_memory;

  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_require;
  logic        memory_write_enable;
  logic [3:0]  memory_byte_enable_map;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        memory_begin_signal;
  logic        memory_end_signal;
  logic        memory_error;

  delayed_data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .memory_require         (memory_require),
    .memory_write_enable    (memory_write_enable),
    .memory_byte_enable_map (memory_byte_enable_map),
    .memory_address         (memory_address),
    .memory_write_data      (memory_write_data),
    .memory_read_data       (memory_read_data),
    .memory_begin_signal    (memory_begin_signal),
    .memory_end_signal      (memory_end_signal),
    .memory_error           (memory_error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rd;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic flagged(input logic [31:0] a);
`ifdef DMEM_BOUND_CHECK_EN
    return a >= 32'(4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // One request; rst_at=k asserts reset right after edge E0+k (0 = none).
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, input int rst_at);
    int          idx;
    logic        oor;
    logic [31:0] new_word;
    logic [31:0] next_rd;
    idx      = word_of(addr);
    oor      = flagged(addr);
    new_word = model_mem[idx];
    next_rd  = exp_rd;
    if (we && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) new_word[8*i +: 8] = wd[8*i +: 8];
      end
    end
    if (!we) next_rd = oor ? 32'd0 : model_mem[idx];
    txn_no++;

    @(negedge clk);
    memory_require         = 1'b1;
    memory_write_enable    = we;
    memory_byte_enable_map = be;
    memory_address         = addr;
    memory_write_data      = wd;
    @(posedge clk); #1;
    check_value("begin_at_accept", {31'd0, memory_begin_signal}, 32'd1);
    check_value("end_at_accept", {31'd0, memory_end_signal}, 32'd0);
    // Request inputs change while busy; only the latched copy may matter.
    memory_require         = hold;
    memory_write_enable    = 1'($urandom);
    memory_byte_enable_map = 4'($urandom);
    memory_address         = $urandom;
    memory_write_data      = $urandom;

    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      check_value("begin_busy", {31'd0, memory_begin_signal}, 32'd0);
      if (k == LAT) begin
        if (we) model_mem[idx] = new_word;
        exp_rd = next_rd;
        check_value("end_at_access", {31'd0, memory_end_signal}, 32'd1);
        check_value("error_at_access", {31'd0, memory_error}, {31'd0, oor});
      end else begin
        check_value("end_idle", {31'd0, memory_end_signal}, 32'd0);
        check_value("error_idle", {31'd0, memory_error}, 32'd0);
      end
      check_value("read_data", memory_read_data, exp_rd);
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        exp_rd = 32'd0;
        check_value("rst_read_data", memory_read_data, 32'd0);
        check_value("rst_begin", {31'd0, memory_begin_signal}, 32'd0);
        check_value("rst_end", {31'd0, memory_end_signal}, 32'd0);
        check_value("rst_error", {31'd0, memory_error}, 32'd0);
        @(negedge clk);
        reset          = 1'b0;
        memory_require = 1'b0;
        repeat (LAT + 1) begin
          @(posedge clk); #1;
          check_value("post_rst_end", {31'd0, memory_end_signal}, 32'd0);
          check_value("post_rst_begin", {31'd0, memory_begin_signal}, 32'd0);
        end
        $display("txn %0d we=%0b be=%b addr=%h wd=%h reset_after_edge=%0d rd=%h",
                 txn_no, we, be, addr, wd, rst_at, memory_read_data);
        return;
      end
    end
    $display("txn %0d we=%0b be=%b addr=%h wd=%h hold=%0b rd=%h err_exp=%0b",
             txn_no, we, be, addr, wd, hold, memory_read_data, oor);
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    memory_require = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_value("idle_begin", {31'd0, memory_begin_signal}, 32'd0);
      check_value("idle_end", {31'd0, memory_end_signal}, 32'd0);
      check_value("idle_read_data", memory_read_data, exp_rd);
    end
  endtask

  initial begin
    logic [31:0] a;
    reset                  = 1'b1;
    memory_require         = 1'b0;
    memory_write_enable    = 1'b0;
    memory_byte_enable_map = 4'd0;
    memory_address         = 32'd0;
    memory_write_data      = 32'd0;
    exp_rd                 = 32'd0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    #1;
    check_value("reset_read_data", memory_read_data, 32'd0);
    check_value("reset_begin", {31'd0, memory_begin_signal}, 32'd0);
    check_value("reset_end", {31'd0, memory_end_signal}, 32'd0);
    check_value("reset_error", {31'd0, memory_error}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // Give every word the bench reads a known value.
    for (int w = 0; w < 20; w++) run_txn(1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0, 0);

    // Full word write then read.
    run_txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 0);
    run_txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 0);
    check_value("spec_word_rd", memory_read_data, 32'hDEADBEEF);

    // Single byte lane over a zero word.
    run_txn(1'b1, 4'hF, 32'h10, 32'h0, 1'b0, 0);
    run_txn(1'b1, 4'b0010, 32'h11, 32'hAAAAAAAA, 1'b0, 0);
    run_txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 0);
    check_value("spec_byte_rd", memory_read_data, 32'h0000AA00);

    // Upper half-word over an all-ones word.
    run_txn(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0, 0);
    run_txn(1'b1, 4'b1100, 32'h22, 32'h12341234, 1'b0, 0);
    run_txn(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 0);
    check_value("spec_half_rd", memory_read_data, 32'h1234FFFF);

    // Empty mask write leaves the word alone.
    run_txn(1'b1, 4'h0, 32'h20, 32'h0BADF00D, 1'b0, 0);
    run_txn(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 0);
    check_value("empty_mask_rd", memory_read_data, 32'h1234FFFF);

    // Require held high with alternating write/read.
    run_txn(1'b1, 4'hF, 32'h30, 32'hCAFE0001, 1'b1, 0);
    run_txn(1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 0);
    run_txn(1'b1, 4'hF, 32'h34, 32'hCAFE0002, 1'b1, 0);
    run_txn(1'b0, 4'hF, 32'h34, 32'h0, 1'b1, 0);
    check_value("hold_rd", memory_read_data, 32'hCAFE0002);
    idle_cycles(2);

    // Reset before the access edge drops the write.
    run_txn(1'b1, 4'hF, 32'h40, 32'h0, 1'b0, 0);
    run_txn(1'b1, 4'hF, 32'h40, 32'h55555555, 1'b0, 1);
    run_txn(1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 0);
    check_value("rst_drop_rd", memory_read_data, 32'h00000000);

    // Reset after the access edge keeps the write.
    run_txn(1'b1, 4'hF, 32'h44, 32'h600DF00D, 1'b0, LAT);
    run_txn(1'b0, 4'hF, 32'h44, 32'h0, 1'b0, 0);
    check_value("rst_keep_rd", memory_read_data, 32'h600DF00D);

    // Address beyond the array: wraps, or is flagged with bound checking.
    run_txn(1'b1, 4'hF, 32'h00001004, 32'hC0FFEE11, 1'b0, 0);
    run_txn(1'b0, 4'hF, 32'h00000004, 32'h0, 1'b0, 0);
`ifndef DMEM_BOUND_CHECK_EN
    check_value("wrap_write_rd", memory_read_data, 32'hC0FFEE11);
`endif
    run_txn(1'b0, 4'hF, 32'h00001000, 32'h0, 1'b0, 0);
`ifdef DMEM_BOUND_CHECK_EN
    check_value("oor_read_zero", memory_read_data, 32'h0);
`endif

    // Random traffic over the preloaded words, some with wrap offsets.
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, 19) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3) * 4 * DEPTH);
      run_txn(1'($urandom), 4'($urandom), a, $urandom, 1'($urandom), 0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
